// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared pointer-width derivation and level arithmetic for both FIFO controllers
package async_fifo_pkg;

   function automatic int pointer_width(input int address_width);
      return address_width + 1;
   endfunction

   // Modular pointer difference truncated to the pointer width.
   function automatic logic [31:0] fifo_level(input logic [31:0] wp, input logic [31:0] rp,
                                              input int ptr_w);
      logic [31:0] mask;
      mask = (32'd1 << ptr_w) - 32'd1;
      return (wp - rp) & mask;
   endfunction

endpackage

// File: rtl/fifo_output_buffer.sv
// rtl/fifo_output_buffer.sv - two-entry skid buffer between memory return and the output stream
module fifo_output_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [1:0]            buffer_count
);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [1:0]            count_q, count_d;
   logic                  pop;

   assign pop          = (count_q != 2'd0) && m_tready;
   assign m_tdata      = head_q;
   assign m_tvalid     = (count_q != 2'd0);
   assign buffer_count = count_q;

   // The upstream issue rule keeps a push away from a full buffer that is not popping.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({pop, s_tvalid})
         2'b01: begin
            if (count_q == 2'd0) begin
               head_d  = s_tdata;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               tail_d  = s_tdata;
               count_d = 2'd2;
            end
         end
         2'b10: begin
            if (count_q == 2'd2) head_d = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = s_tdata;
            end else begin
               head_d = tail_q;
               tail_d = s_tdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/async_fifo_read_controller.sv
// rtl/async_fifo_read_controller.sv - read-clock-domain side of the dual-clock FIFO
module async_fifo_read_controller
   import async_fifo_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     read_clock,
   input  logic                     read_reset_n,
   input  logic [ADDRESS_WIDTH:0]   write_pointer,
   output logic [ADDRESS_WIDTH:0]   read_pointer,
   output logic                     memory_read_enable,
   output logic [ADDRESS_WIDTH-1:0] memory_read_address,
   input  logic [DATA_WIDTH-1:0]    memory_read_data,
   output logic [DATA_WIDTH-1:0]    data,
   output logic                     data_valid,
   input  logic                     data_ready,
   output logic                     memory_empty,
   output logic [ADDRESS_WIDTH:0]   fill_level,
   output logic                     pointer_error
);

   localparam int PTR_W = pointer_width(ADDRESS_WIDTH);
   localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   logic [PTR_W-1:0] read_pointer_q, read_pointer_d;
   logic             in_flight_q, in_flight_d;
   logic             pointer_error_q, pointer_error_d;
   logic [1:0]       buffer_count;
   logic [2:0]       outstanding;
   logic             pop;
   logic             issue;

   assign memory_empty        = (write_pointer == read_pointer_q);
   assign fill_level          = PTR_W'(fifo_level(32'(write_pointer), 32'(read_pointer_q), PTR_W));
   assign pop                 = data_valid && data_ready;
   assign outstanding         = 3'(buffer_count) + 3'(in_flight_q) - 3'(pop);
   // Gating with the reset keeps the strobe quiet while reset is held with a live write pointer.
   assign issue               = read_reset_n && !memory_empty && !pointer_error_q && (outstanding < 3'd2);
   assign memory_read_enable  = issue;
   assign memory_read_address = read_pointer_q[ADDRESS_WIDTH-1:0];
   assign read_pointer        = read_pointer_q;
   assign pointer_error       = pointer_error_q;

   always_comb begin
      read_pointer_d  = read_pointer_q + PTR_W'(issue);
      in_flight_d     = issue;
      pointer_error_d = pointer_error_q || (fill_level > DEPTH);
   end

   always_ff @(posedge read_clock or negedge read_reset_n) begin
      if (!read_reset_n) begin
         read_pointer_q  <= '0;
         in_flight_q     <= 1'b0;
         pointer_error_q <= 1'b0;
      end else begin
         read_pointer_q  <= read_pointer_d;
         in_flight_q     <= in_flight_d;
         pointer_error_q <= pointer_error_d;
      end
   end

   fifo_output_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_output_buffer (
      .clk          (read_clock),
      .rst_n        (read_reset_n),
      .s_tdata      (memory_read_data),
      .s_tvalid     (in_flight_q),
      .m_tdata      (data),
      .m_tvalid     (data_valid),
      .m_tready     (data_ready),
      .buffer_count (buffer_count)
   );

endmodule

// File: tb/tb_async_fifo_read_controller.sv
// tb/tb_async_fifo_read_controller.sv - directed bench for the FIFO read controller
module tb_async_fifo_read_controller;

   logic       read_clock = 1'b0;
   logic       read_reset_n = 1'b0;
   logic [4:0] write_pointer = 5'd0;
   logic [4:0] read_pointer;
   logic       memory_read_enable;
   logic [3:0] memory_read_address;
   logic [7:0] memory_read_data = 8'd0;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready = 1'b0;
   logic       memory_empty;
   logic [4:0] fill_level;
   logic       pointer_error;

   int tests = 0;
   int fails = 0;
   logic [7:0] mem [16];

   typedef struct {
      logic [4:0] wp;
      logic       rdy;
      logic       en;
      logic       vld;
      logic [7:0] dat;
      logic [4:0] rp;
      logic [4:0] fill;
   } vec_t;
   vec_t vt [11];

   async_fifo_read_controller #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
      .read_clock          (read_clock),
      .read_reset_n        (read_reset_n),
      .write_pointer       (write_pointer),
      .read_pointer        (read_pointer),
      .memory_read_enable  (memory_read_enable),
      .memory_read_address (memory_read_address),
      .memory_read_data    (memory_read_data),
      .data                (data),
      .data_valid          (data_valid),
      .data_ready          (data_ready),
      .memory_empty        (memory_empty),
      .fill_level          (fill_level),
      .pointer_error       (pointer_error)
   );

   always #5 read_clock = ~read_clock;

   always @(posedge read_clock) begin
      if (memory_read_enable) memory_read_data <= mem[memory_read_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      read_reset_n  = 1'b0;
      write_pointer = 5'd0;
      data_ready    = 1'b0;
      repeat (2) @(posedge read_clock);
      #1 read_reset_n = 1'b1;
   endtask

   task automatic run_drain(input int n, input int first);
      int ni = 0;
      int np = 0;
      data_ready = 1'b1;
      for (int c = 0; c < 4 * n + 10 && np < n; c++) begin
         @(negedge read_clock);
         if (memory_read_enable) begin
            check("drain_addr", 32'(memory_read_address), 32'((first + ni) % 16));
            ni++;
         end
         if (data_valid) begin
            check("drain_data", 32'(data), 32'(mem[(first + np) % 16]));
            np++;
         end
         @(posedge read_clock);
         #1;
      end
      check("drain_pops", np, n);
      check("drain_issues", ni, n);
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 3);
      mem[0] = 8'hA5;
      mem[1] = 8'h11;
      mem[2] = 8'h22;

      vt[0]  = '{5'd1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 5'd1};
      vt[1]  = '{5'd1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 5'd0};
      vt[2]  = '{5'd1, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd1, 5'd0};
      vt[3]  = '{5'd1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 5'd0};
      vt[4]  = '{5'd3, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 5'd2};
      vt[5]  = '{5'd3, 1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 5'd1};
      vt[6]  = '{5'd3, 1'b0, 1'b0, 1'b1, 8'h11, 5'd3, 5'd0};
      vt[7]  = '{5'd3, 1'b0, 1'b0, 1'b1, 8'h11, 5'd3, 5'd0};
      vt[8]  = '{5'd3, 1'b1, 1'b0, 1'b1, 8'h11, 5'd3, 5'd0};
      vt[9]  = '{5'd3, 1'b1, 1'b0, 1'b1, 8'h22, 5'd3, 5'd0};
      vt[10] = '{5'd3, 1'b1, 1'b0, 1'b0, 8'h00, 5'd3, 5'd0};

      #2;
      check("rst_rp", 32'(read_pointer), 0);
      check("rst_valid", 32'(data_valid), 0);
      check("rst_data", 32'(data), 0);
      check("rst_en", 32'(memory_read_enable), 0);
      check("rst_empty", 32'(memory_empty), 1);
      check("rst_fill", 32'(fill_level), 0);
      check("rst_err", 32'(pointer_error), 0);
      do_reset();

      // First word, then a short stall with two buffered entries.
      for (int i = 0; i < 11; i++) begin
         write_pointer = vt[i].wp;
         data_ready    = vt[i].rdy;
         @(negedge read_clock);
         check($sformatf("vec%0d_en", i), 32'(memory_read_enable), 32'(vt[i].en));
         check($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vt[i].vld));
         if (vt[i].vld) check($sformatf("vec%0d_data", i), 32'(data), 32'(vt[i].dat));
         check($sformatf("vec%0d_rp", i), 32'(read_pointer), 32'(vt[i].rp));
         check($sformatf("vec%0d_addr", i), 32'(memory_read_address), 32'(vt[i].rp[3:0]));
         check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vt[i].fill));
         check($sformatf("vec%0d_empty", i), 32'(memory_empty), 32'(vt[i].fill == 5'd0));
         @(posedge read_clock);
         #1;
      end

      // Burst of 8 with 5 stalled cycles.
      write_pointer = 5'd11;
      data_ready    = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge read_clock);
         if (memory_read_enable) cnt++;
         @(posedge read_clock);
         #1;
      end
      check("burst_stall_reads", cnt, 2);
      data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge read_clock);
         check($sformatf("burst_en%0d", i), 32'(memory_read_enable), 32'(i < 6));
         check($sformatf("burst_valid%0d", i), 32'(data_valid), 1);
         check($sformatf("burst_data%0d", i), 32'(data), 32'(mem[3 + i]));
         @(posedge read_clock);
         #1;
      end
      check("burst_rp", 32'(read_pointer), 11);

      // Reset while two entries sit in the buffer.
      write_pointer = 5'd16;
      data_ready    = 1'b0;
      repeat (4) begin
         @(posedge read_clock);
         #1;
      end
      @(negedge read_clock);
      check("pre_rst_valid", 32'(data_valid), 1);
      read_reset_n = 1'b0;
      #1;
      check("mid_rst_rp", 32'(read_pointer), 0);
      check("mid_rst_valid", 32'(data_valid), 0);
      check("mid_rst_data", 32'(data), 0);
      check("mid_rst_en", 32'(memory_read_enable), 0);
      check("mid_rst_err", 32'(pointer_error), 0);
      write_pointer = 5'd0;
      repeat (2) @(posedge read_clock);
      #1 read_reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge read_clock);
         check("post_rst_en", 32'(memory_read_enable), 0);
         check("post_rst_empty", 32'(memory_empty), 1);
         @(posedge read_clock);
         #1;
      end

      // Jump of a full depth in one step.
      write_pointer = 5'd16;
      #1;
      check("jump_fill", 32'(fill_level), 16);
      run_drain(16, 0);
      check("jump_err", 32'(pointer_error), 0);
      check("jump_rp", 32'(read_pointer), 16);

      // Move to read_pointer 30, then wrap the address space.
      write_pointer = 5'd30;
      #1;
      run_drain(14, 0);
      check("pre_wrap_rp", 32'(read_pointer), 30);
      write_pointer = 5'd2;
      #1;
      check("wrap_fill", 32'(fill_level), 4);
      run_drain(4, 14);
      check("wrap_rp", 32'(read_pointer), 2);
      check("wrap_empty", 32'(memory_empty), 1);

      // Overfull pointer distance sets the sticky error.
      do_reset();
      write_pointer = 5'd17;
      data_ready    = 1'b1;
      #1;
      check("err_fill", 32'(fill_level), 17);
      @(posedge read_clock);
      #1;
      for (int i = 0; i < 6; i++) begin
         @(negedge read_clock);
         check($sformatf("err_set%0d", i), 32'(pointer_error), 1);
         check($sformatf("err_noread%0d", i), 32'(memory_read_enable), 0);
         @(posedge read_clock);
         #1;
      end
      do_reset();
      check("err_cleared", 32'(pointer_error), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
